// File: rtl/xcorr_pkg.sv
// Shared types and sizing helpers for the cross-correlation engine.
package xcorr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_F,
    ST_LOAD_G,
    ST_MAC,
    ST_CMP,
    ST_DONE
  } state_e;

  function automatic int clog2(input int unsigned v);
    int          r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  // Sign bit plus headroom for M full-precision products.
  function automatic int acc_width(input int dw, input int m);
    return 2 * dw + clog2(m) + 1;
  endfunction

  function automatic int pos_width(input int n);
    return clog2(n);
  endfunction

  // A depth-1 memory still needs a 1-bit address.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/xcorr_engine_if.sv
// Sample-stream handshake into the correlation engine.
interface xcorr_engine_if #(
  parameter int DW = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/xcorr_sample_ram.sv
// Reference (f) and template (g) sample stores, synchronous read, no reset.
module xcorr_sample_ram
  import xcorr_pkg::*;
#(
  parameter int DW = 8,
  parameter int N  = 1024,
  parameter int M  = 64,
  localparam int FAW = addr_width(N),
  localparam int GAW = addr_width(M)
) (
  input  logic                 clk,
  input  logic                 f_we,
  input  logic [FAW-1:0]       f_waddr,
  input  logic                 g_we,
  input  logic [GAW-1:0]       g_waddr,
  input  logic signed [DW-1:0] wdata,
  input  logic                 re,
  input  logic [FAW-1:0]       f_raddr,
  input  logic [GAW-1:0]       g_raddr,
  output logic signed [DW-1:0] f_rdata,
  output logic signed [DW-1:0] g_rdata
);

  logic signed [DW-1:0] f_mem [N];
  logic signed [DW-1:0] g_mem [M];

  always_ff @(posedge clk) begin
    if (f_we) f_mem[f_waddr] <= wdata;
    if (g_we) g_mem[g_waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) begin
      f_rdata <= f_mem[f_raddr];
      g_rdata <= g_mem[g_raddr];
    end
  end

endmodule

// File: rtl/xcorr_engine.sv
// Sliding cross-correlation of an M-tap template over an N-sample reference,
// one product per cycle, tracking the best lag (signed or magnitude).
module xcorr_engine
  import xcorr_pkg::*;
#(
  parameter int DW = 8,
  parameter int N  = 1024,
  parameter int M  = 64,
  localparam int ACCW = acc_width(DW, M),
  localparam int PW   = pos_width(N)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   mode,
  xcorr_engine_if.slave          in_if,
  output logic                   busy,
  output logic                   lag_valid,
  output logic [PW-1:0]          lag_idx,
  output logic signed [ACCW-1:0] lag_sum,
  output logic                   done,
  output logic signed [ACCW-1:0] max_val,
  output logic [PW-1:0]          max_pos
);

  localparam int GAW = addr_width(M);
  localparam logic [PW-1:0] LAST_F   = PW'(N - 1);
  localparam logic [PW-1:0] LAST_G   = PW'(M - 1);
  localparam logic [PW-1:0] LAST_TAP = PW'(M - 1);
  localparam logic [PW-1:0] LAST_X   = PW'(N - M);

  state_e                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic [PW-1:0]          load_q, load_d;
  logic [PW-1:0]          tap_q, tap_d;
  logic [PW-1:0]          x_q, x_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [ACCW-1:0] max_q, max_d;
  logic [PW-1:0]          pos_q, pos_d;

  logic                   ready;
  logic                   accept;
  logic                   rd_en;
  logic signed [DW-1:0]   f_rd, g_rd;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] sum;
  logic signed [ACCW-1:0] cand;

  assign ready  = (state_q == ST_LOAD_F) || (state_q == ST_LOAD_G);
  assign accept = in_if.in_valid && ready;
  assign rd_en  = (state_q == ST_MAC);
  assign in_if.in_ready = ready;

  xcorr_sample_ram #(
    .DW (DW),
    .N  (N),
    .M  (M)
  ) u_ram (
    .clk     (clk),
    .f_we    (accept && (state_q == ST_LOAD_F)),
    .f_waddr (load_q),
    .g_we    (accept && (state_q == ST_LOAD_G)),
    .g_waddr (load_q[GAW-1:0]),
    .wdata   (in_if.in_data),
    .re      (rd_en),
    .f_raddr (x_q + tap_q),
    .g_raddr (tap_q[GAW-1:0]),
    .f_rdata (f_rd),
    .g_rdata (g_rd)
  );

  // Read data trails the tap counter by one cycle: MAC tap k adds product k-1
  // and CMP folds in the last product combinationally, keeping M+1 cycles/lag.
  assign prod     = f_rd * g_rd;
  assign prod_ext = {{(ACCW - 2 * DW){prod[2*DW-1]}}, prod};
  assign sum      = acc_q + prod_ext;
  assign cand     = (mode_q && sum[ACCW-1]) ? -sum : sum;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      load_q  <= '0;
      tap_q   <= '0;
      x_q     <= '0;
      acc_q   <= '0;
      max_q   <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      load_q  <= load_d;
      tap_q   <= tap_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      max_q   <= max_d;
      pos_q   <= pos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    load_d  = load_q;
    tap_d   = tap_q;
    x_d     = x_q;
    acc_d   = acc_q;
    max_d   = max_q;
    pos_d   = pos_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD_F;
          mode_d  = mode;
          load_d  = '0;
          max_d   = '0;
          pos_d   = '0;
        end
      end
      ST_LOAD_F: begin
        if (accept) begin
          if (load_q == LAST_F) begin
            state_d = ST_LOAD_G;
            load_d  = '0;
          end else begin
            load_d = load_q + 1'b1;
          end
        end
      end
      ST_LOAD_G: begin
        if (accept) begin
          if (load_q == LAST_G) begin
            state_d = ST_MAC;
            load_d  = '0;
            tap_d   = '0;
            x_d     = '0;
          end else begin
            load_d = load_q + 1'b1;
          end
        end
      end
      ST_MAC: begin
        acc_d = (tap_q == '0) ? '0 : sum;
        if (tap_q == LAST_TAP) begin
          state_d = ST_CMP;
          tap_d   = '0;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      ST_CMP: begin
        if ((x_q == '0) || (cand > max_q)) begin
          max_d = cand;
          pos_d = x_q;
        end
        if (x_q == LAST_X) begin
          state_d = ST_DONE;
        end else begin
          x_d     = x_q + 1'b1;
          state_d = ST_MAC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = !(state_q inside {ST_IDLE, ST_DONE});
  assign lag_valid = (state_q == ST_CMP);
  assign lag_idx   = lag_valid ? x_q : '0;
  assign lag_sum   = lag_valid ? sum : '0;
  assign done      = (state_q == ST_DONE);
  assign max_val   = max_q;
  assign max_pos   = pos_q;

endmodule

// File: tb/tb_xcorr_engine.sv
// Directed checks of xcorr_engine with N=16, M=4, DW=8.
module tb_xcorr_engine;

  logic               clk;
  logic               reset_n;
  logic               start;
  logic               mode;
  logic               busy;
  logic               lag_valid;
  logic [3:0]         lag_idx;
  logic signed [18:0] lag_sum;
  logic               done;
  logic signed [18:0] max_val;
  logic [3:0]         max_pos;

  xcorr_engine_if #(.DW(8)) bus ();

  xcorr_engine #(
    .DW (8),
    .N  (16),
    .M  (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .mode      (mode),
    .in_if     (bus),
    .busy      (busy),
    .lag_valid (lag_valid),
    .lag_idx   (lag_idx),
    .lag_sum   (lag_sum),
    .done      (done),
    .max_val   (max_val),
    .max_pos   (max_pos)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int ncmp = 0;
  int nerr = 0;

  logic signed [7:0]  f_vec [16];
  logic signed [7:0]  g_vec [4];
  logic signed [18:0] sums  [16];
  logic [3:0]         idxs  [16];
  int npulse;
  int done_k;
  int pulses_after_rst;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int golden(input int x);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += int'(f_vec[x+k]) * int'(g_vec[k]);
    return s;
  endfunction

  task automatic check_zero_outputs(input string nm);
    check({nm, ".busy"},      busy,         0);
    check({nm, ".in_ready"},  bus.in_ready, 0);
    check({nm, ".lag_valid"}, lag_valid,    0);
    check({nm, ".lag_idx"},   lag_idx,      0);
    check({nm, ".lag_sum"},   lag_sum,      0);
    check({nm, ".done"},      done,         0);
    check({nm, ".max_val"},   max_val,      0);
    check({nm, ".max_pos"},   max_pos,      0);
  endtask

  // Start, stream f then g, then watch lag pulses until done or budget.
  task automatic run_case(input string nm, input logic m, input int gap_at,
                          input int start_at, input int rst_at, input bit junk);
    npulse = 0;
    done_k = 0;
    pulses_after_rst = 0;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
    check({nm, ".clr_done"}, done,         0);
    check({nm, ".clr_max"},  max_val,      0);
    check({nm, ".clr_pos"},  max_pos,      0);
    check({nm, ".busy"},     busy,         1);
    check({nm, ".ready"},    bus.in_ready, 1);
    for (int i = 0; i < 20; i++) begin
      if (i == gap_at) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'sd77;
        repeat (3) @(negedge clk);
      end
      bus.in_valid = 1'b1;
      if (i < 16) bus.in_data = f_vec[i];
      else        bus.in_data = g_vec[i-16];
      @(negedge clk);
    end
    bus.in_valid = junk;
    bus.in_data  = 8'sd99;
    for (int k = 1; k <= 120; k++) begin
      start = (k == start_at);
      if (k == rst_at) reset_n = 1'b0;
      if (rst_at > 0 && k == rst_at + 1) begin
        check_zero_outputs({nm, ".rst"});
        reset_n = 1'b1;
      end
      if (lag_valid) begin
        if (npulse < 16) begin
          sums[npulse] = lag_sum;
          idxs[npulse] = lag_idx;
        end
        npulse++;
        if (rst_at > 0 && k > rst_at) pulses_after_rst++;
      end
      if (done) begin
        done_k = k;
        break;
      end
      @(negedge clk);
    end
    start        = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_run(input string nm, input int exp_max, input int exp_pos);
    check({nm, ".pulses"},  npulse,  13);
    check({nm, ".latency"}, done_k,  66);
    for (int x = 0; x < 13; x++) begin
      check($sformatf("%s.sum%0d", nm, x), sums[x], golden(x));
      check($sformatf("%s.idx%0d", nm, x), idxs[x], x);
    end
    check({nm, ".max_val"}, max_val, exp_max);
    check({nm, ".max_pos"}, max_pos, exp_pos);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) f_vec[i] = 8'sd0;
    f_vec[5] = 8'sd1; f_vec[6] = 8'sd2; f_vec[7] = 8'sd3; f_vec[8] = 8'sd4;
    g_vec[0] = 8'sd1; g_vec[1] = 8'sd2; g_vec[2] = 8'sd3; g_vec[3] = 8'sd4;
  endtask

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    mode         = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset_n = 1'b1;

    // Samples offered in IDLE must be ignored.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'sd55;
    repeat (3) @(negedge clk);
    check("idle.ready", bus.in_ready, 0);
    check("idle.busy",  busy,         0);
    bus.in_valid = 1'b0;

    for (int i = 0; i < 16; i++) f_vec[i] = 8'sd1;
    for (int i = 0; i < 4; i++)  g_vec[i] = 8'sd1;
    run_case("ones", 1'b0, -1, 0, 0, 1'b0);
    check_run("ones", 4, 0);
    check("ones.sum7", sums[7], 4);

    load_ramp();
    run_case("ramp", 1'b0, -1, 0, 0, 1'b0);
    check_run("ramp", 30, 5);
    check("ramp.sum4", sums[4], 20);

    for (int i = 0; i < 16; i++) f_vec[i] = -8'sd1;
    for (int i = 0; i < 4; i++)  g_vec[i] = 8'sd1;
    run_case("neg", 1'b0, -1, 0, 0, 1'b0);
    check_run("neg", -4, 0);

    for (int i = 0; i < 16; i++) f_vec[i] = 8'sd0;
    f_vec[2] = -8'sd1; f_vec[3] = -8'sd2; f_vec[4] = -8'sd3; f_vec[5] = -8'sd4;
    for (int i = 10; i < 14; i++) f_vec[i] = 8'sd1;
    g_vec[0] = 8'sd1; g_vec[1] = 8'sd2; g_vec[2] = 8'sd3; g_vec[3] = 8'sd4;
    run_case("mix_m0", 1'b0, -1, 0, 0, 1'b0);
    check_run("mix_m0", 10, 10);
    check("mix_m0.sum2", sums[2], -30);

    for (int i = 0; i < 16; i++) f_vec[i] = -8'sd128;
    for (int i = 0; i < 4; i++)  g_vec[i] = -8'sd128;
    run_case("min", 1'b0, -1, 0, 0, 1'b0);
    check_run("min", 65536, 0);
    check("min.sum12", sums[12], 65536);

    // Load gap, start pulse during MAC and samples offered while not ready.
    load_ramp();
    run_case("gap", 1'b0, 10, 7, 0, 1'b1);
    check_run("gap", 30, 5);

    load_ramp();
    run_case("abort", 1'b0, -1, 0, 8, 1'b0);
    check("abort.done_k",     done_k,           0);
    check("abort.pulses_aft", pulses_after_rst, 0);
    check("abort.busy",       busy,             0);
    check("abort.done",       done,             0);

    for (int i = 0; i < 16; i++) f_vec[i] = 8'sd0;
    f_vec[2] = -8'sd1; f_vec[3] = -8'sd2; f_vec[4] = -8'sd3; f_vec[5] = -8'sd4;
    for (int i = 10; i < 14; i++) f_vec[i] = 8'sd1;
    g_vec[0] = 8'sd1; g_vec[1] = 8'sd2; g_vec[2] = 8'sd3; g_vec[3] = 8'sd4;
    run_case("mix_m1", 1'b1, -1, 0, 0, 1'b0);
    check_run("mix_m1", 30, 2);
    check("mix_m1.sum10", sums[10], 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
